// File: rtl/contador_pkg.sv
// contador_pkg: shared states, constants and BCD increment helper for the millisecond counter
package contador_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;
  localparam int TICK_DIV_DEF = 100000;
  localparam int BCD_DIGITS = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  // Returns {carry_out, value+1} with decimal carry across all digits
  function automatic logic [4*BCD_DIGITS:0] bcd_inc(input logic [4*BCD_DIGITS-1:0] v);
    logic c;
    logic [4*BCD_DIGITS-1:0] r;
    c = 1'b1;
    r = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (c) begin
        c = (v[4*i +: 4] == BCD_MAX);
        r[4*i +: 4] = c ? 4'd0 : v[4*i +: 4] + 4'd1;
      end
    end
    return {c, r};
  endfunction
endpackage

// File: rtl/contador_prescaler.sv
// contador_prescaler: gated, clearable divider; TICK flags the enabled edge on which it wraps
module contador_prescaler
  import contador_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int PRESC_W  = 19
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  input  logic EN,
  output logic TICK
);
  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICK_DIV - 1);
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  assign TICK = EN && !CLR && (cnt_q == LAST);
  always_comb begin
    cnt_d = CLR ? '0 : !EN ? cnt_q : TICK ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (!RST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/contador_ms_ctrl.sv
// contador_ms_ctrl: run/pause/clear FSM driving a 1 ms prescaler and 4-digit BCD count.
// Define CONTADOR_LAP_EN to enable the LAP display-hold feature.
module contador_ms_ctrl
  import contador_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int PRESC_W  = 19
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        STOP,
  input  logic        CLEAR,
  input  logic        LAP,
  output logic [15:0] MS_BCD,
  output logic        RUNNING,
  output logic        TICK,
  output logic        OVF
);
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        tick_q, ovf_q;
  logic        presc_en, presc_clr, wrap;
  logic [16:0] inc;
  assign inc = bcd_inc(cnt_q);
  contador_prescaler #(.TICK_DIV(TICK_DIV), .PRESC_W(PRESC_W)) u_presc (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (presc_clr),
    .EN   (presc_en),
    .TICK (wrap)
  );
  // STOP and CLEAR gate the prescaler on their own edge so a coincident wrap is suppressed
  always_comb begin
    state_d   = state_q;
    presc_en  = 1'b0;
    presc_clr = 1'b0;
    cnt_d     = cnt_q;
    state_d   = CLEAR ? IDLE :
                (state_q == RUN)   ? (STOP ? PAUSE : RUN) :
                (state_q == PAUSE) ? ((STOP || !START) ? PAUSE : RUN) :
                (START ? RUN : IDLE);
    presc_en  = (state_q == RUN) && !STOP && !CLEAR;
    presc_clr = CLEAR || (state_q == IDLE);
    cnt_d     = CLEAR ? 16'h0000 : wrap ? inc[15:0] : cnt_q;
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= 16'h0000;
      tick_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= wrap;
      ovf_q   <= wrap && inc[16];
    end
  end
  assign RUNNING = (state_q == RUN);
  assign TICK    = tick_q;
  assign OVF     = ovf_q;
`ifdef CONTADOR_LAP_EN
  logic        hold_q, hold_d;
  logic [15:0] lap_q, lap_d;
  always_comb begin
    hold_d = hold_q;
    lap_d  = lap_q;
    hold_d = CLEAR ? 1'b0 : (LAP && state_q != IDLE) ? !hold_q : hold_q;
    lap_d  = (LAP && state_q != IDLE && !hold_q) ? cnt_q : lap_q;
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      hold_q <= 1'b0;
      lap_q  <= 16'h0000;
    end else begin
      hold_q <= hold_d;
      lap_q  <= lap_d;
    end
  end
  assign MS_BCD = hold_q ? lap_q : cnt_q;
`else
  logic unused_lap;
  assign unused_lap = LAP;
  assign MS_BCD     = cnt_q;
`endif
endmodule

// File: tb/tb_contador_ms_ctrl.sv
// tb_contador_ms_ctrl: scoreboard bench; TICK_DIV=10 main DUT, TICK_DIV=2 DUT for the 9999->0000 wrap
module tb_contador_ms_ctrl;
  typedef struct {
    int          e;
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [15:0] ms_bcd;
  logic        running, tick, ovf;
  logic        start2 = 1'b0;
  logic [15:0] ms_bcd2;
  logic        running2, tick2, ovf2;
  int          ecnt = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q1[$];
  exp_t        q2[$];

  contador_ms_ctrl #(.TICK_DIV(10), .PRESC_W(19)) dut (
    .CLK(clk), .RST(rst), .START(start), .STOP(stop), .CLEAR(clear), .LAP(lap),
    .MS_BCD(ms_bcd), .RUNNING(running), .TICK(tick), .OVF(ovf)
  );

  contador_ms_ctrl #(.TICK_DIV(2), .PRESC_W(4)) dut2 (
    .CLK(clk), .RST(rst), .START(start2), .STOP(1'b0), .CLEAR(1'b0), .LAP(1'b0),
    .MS_BCD(ms_bcd2), .RUNNING(running2), .TICK(tick2), .OVF(ovf2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push1(input int e, input int v, input logic o);
    exp_t x;
    x.e = e; x.bcd = to_bcd(v); x.ovf = o;
    q1.push_back(x);
  endtask

  // Monitors: every TICK must match the head of its queue; OVF only ever rides on a TICK
  always @(negedge clk) begin
    if (rst && (tick || ovf)) begin
      if (ovf && !tick) check("ovf_without_tick", 32'(ovf), 32'(0));
      else if (q1.size() == 0) check("unexpected_tick", {16'(ecnt), ms_bcd}, 32'(0));
      else begin
        exp_t x;
        x = q1.pop_front();
        check("tick_edge", 32'(ecnt), 32'(x.e));
        check("tick_bcd", 32'(ms_bcd), 32'(x.bcd));
        check("tick_ovf", 32'(ovf), 32'(x.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && (tick2 || ovf2)) begin
      if (ovf2 && !tick2) check("ovf2_without_tick", 32'(ovf2), 32'(0));
      else if (q2.size() == 0) check("unexpected_tick2", {16'(ecnt), ms_bcd2}, 32'(0));
      else begin
        exp_t x;
        x = q2.pop_front();
        if (ecnt !== x.e || ms_bcd2 !== x.bcd || ovf2 !== x.ovf || x.ovf) begin
          check("wrap_edge", 32'(ecnt), 32'(x.e));
          check("wrap_bcd", 32'(ms_bcd2), 32'(x.bcd));
          check("wrap_ovf", 32'(ovf2), 32'(x.ovf));
        end else checks++;
      end
    end
  end

  initial begin
    int s;
    step(3);
    check("rst_bcd", 32'(ms_bcd), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    rst = 1'b1;
    step(2);
    // Basic run: ticks at +10, +20, +30
    start = 1'b1; step(1); start = 1'b0; s = ecnt;
    check("start_running", 32'(running), 32'h1);
    push1(s + 10, 1, 1'b0); push1(s + 20, 2, 1'b0); push1(s + 30, 3, 1'b0);
    step(31);
    check("run_bcd3", 32'(ms_bcd), 32'h0003);
    clear = 1'b1; step(1); clear = 1'b0;
    check("clear_bcd", 32'(ms_bcd), 32'h0);
    check("clear_running", 32'(running), 32'h0);
    // Pause with a partial millisecond of 5 retained
    start = 1'b1; step(1); start = 1'b0; s = ecnt;
    push1(s + 10, 1, 1'b0); push1(s + 20, 2, 1'b0);
    step(25);
    stop = 1'b1; step(1); stop = 1'b0;
    check("stop_running", 32'(running), 32'h0);
    step(40);
    check("pause_bcd", 32'(ms_bcd), 32'h0002);
    start = 1'b1; step(1); start = 1'b0; s = ecnt;
    push1(s + 5, 3, 1'b0);
    step(6);
    check("resume_bcd", 32'(ms_bcd), 32'h0003);
    // STOP on a wrap edge: no tick, prescaler parks at 9 so resume ticks one edge later
    step(8);
    stop = 1'b1; step(1); stop = 1'b0;
    check("stopwrap_running", 32'(running), 32'h0);
    check("stopwrap_bcd", 32'(ms_bcd), 32'h0003);
    start = 1'b1; step(1); start = 1'b0; s = ecnt;
    push1(s + 1, 4, 1'b0);
    step(2);
    check("stopwrap_resume_bcd", 32'(ms_bcd), 32'h0004);
    // CLEAR on a wrap edge wins over the tick
    step(8);
    clear = 1'b1; step(1); clear = 1'b0;
    check("clearwrap_bcd", 32'(ms_bcd), 32'h0);
    check("clearwrap_tick", 32'(tick), 32'h0);
    check("clearwrap_running", 32'(running), 32'h0);
    // START+STOP+CLEAR in RUN -> IDLE
    start = 1'b1; step(1); start = 1'b0;
    step(3);
    start = 1'b1; stop = 1'b1; clear = 1'b1; step(1);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    check("all3_running", 32'(running), 32'h0);
    step(15);
    check("all3_idle_bcd", 32'(ms_bcd), 32'h0);
    // START+STOP in IDLE -> RUN
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0; s = ecnt;
    check("idle_startstop_running", 32'(running), 32'h1);
    push1(s + 10, 1, 1'b0);
    step(11);
    check("idle_startstop_bcd", 32'(ms_bcd), 32'h0001);
    // START+STOP in PAUSE stays in PAUSE
    stop = 1'b1; step(1); stop = 1'b0;
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    check("pause_startstop_running", 32'(running), 32'h0);
    start = 1'b1; step(1); start = 1'b0;
    check("pause_start_running", 32'(running), 32'h1);
    // Mid-run reset
    step(3);
    rst = 1'b0; step(1);
    check("midrst_bcd", 32'(ms_bcd), 32'h0);
    check("midrst_running", 32'(running), 32'h0);
    check("midrst_tick", 32'(tick), 32'h0);
    rst = 1'b1; step(1);
`ifdef CONTADOR_LAP_EN
    start = 1'b1; step(1); start = 1'b0; s = ecnt;
    for (int i = 1; i <= 7; i++) push1(s + 10 * i, (i <= 4) ? i : 4, 1'b0);
    step(44);
    lap = 1'b1; step(1); lap = 1'b0;
    step(30);
    check("lap_hold_bcd", 32'(ms_bcd), 32'h0004);
    lap = 1'b1; step(1); lap = 1'b0;
    check("lap_release_bcd", 32'(ms_bcd), 32'h0007);
    clear = 1'b1; step(1); clear = 1'b0;
    check("lap_clear_bcd", 32'(ms_bcd), 32'h0);
`endif
    // Full 9999 -> 0000 wrap on the fast instance
    start2 = 1'b1; step(1); start2 = 1'b0; s = ecnt;
    for (int i = 1; i <= 10000; i++) begin
      exp_t x;
      x.e = s + 2 * i; x.bcd = to_bcd(i % 10000); x.ovf = (i == 10000);
      q2.push_back(x);
    end
    step(19998);
    check("pre_wrap_bcd", 32'(ms_bcd2), 32'h9999);
    step(3);
    check("post_wrap_bcd", 32'(ms_bcd2), 32'h0);
    check("post_wrap_running", 32'(running2), 32'h1);
    check("q1_drained", 32'(q1.size()), 32'h0);
    check("q2_drained", 32'(q2.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
